decode_stage_pipe: RTL and testbench
====================================

Name: decode_stage_pipe

Overview:
Parametrised decode-to-execute stage for the pipelined RISC-V core. Holds the architectural register file, WB→ID bypass, load-use hazard detection with configurable load latency, and branch-flush support, and drives the ID/EX pipeline register with an explicit valid bit. Opcode decode is external; the packed control bundle is passed through. Sits between the IF/ID register and the execute stage.

Parameters:
XLEN, 32, datapath/PC width
REG_ADDR_W, 5, register index width; register count = 2**REG_ADDR_W
CTRL_W, 8, width of opaque control bundle (ALU op, ALUSrc, branch, memwrite, memtoreg…)
LOAD_LAT, 1, total load-use stall cycles; legal values ≥1

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
valid_d  in  1  IF/ID holds a real instruction
ins_d  in  32  instruction; rs1=[19:15], rs2=[24:20], rd=[11:7] (low REG_ADDR_W bits used)
pc_d, pc4_d  in  XLEN  PC and PC+4 of D instruction
imm_d  in  XLEN  extended immediate
ctrl_d  in  CTRL_W  decoded control bundle
reg_write_d, mem_read_d, uses_rs1_d, uses_rs2_d  in  1 each  decoded flags
flush_e  in  1  branch/jump redirect resolved in E; kills D instruction
reg_write_w  in  1  WB write enable
rd_w  in  REG_ADDR_W  WB destination
result_w  in  XLEN  WB data
valid_e, reg_write_e, mem_read_e  out  1 each  ID/EX register
ctrl_e  out  CTRL_W  ID/EX control
imm_e, rdata1_e, rdata2_e, pc_e, pc4_e  out  XLEN  ID/EX data
rs1_e, rs2_e, rd_e  out  REG_ADDR_W  ID/EX register indices
pc_write, if_id_write  out  1  front-end enables (0 = hold)
stall_d  out  1  load-use stall active this cycle

Behaviour:
- Reset (async): all ID/EX outputs 0, all registers 0, stall counter 0; consequently pc_write=if_id_write=1, stall_d=0.
- Register file: write at posedge when reg_write_w && rd_w!=0; x0 reads 0 always. Read combinational.
- Bypass: rdataN = result_w when reg_write_w && rd_w!=0 && rd_w==rsN, else array value.
- Hazard detect (comb): hit = valid_d && valid_e && mem_read_e && rd_e!=0 && ((uses_rs1_d && rs1==rd_e) || (uses_rs2_d && rs2==rd_e)).
- Stall counter cnt (0..LOAD_LAT-1): stall_d = (hit && cnt==0) || cnt!=0. On hit with cnt==0: cnt<=LOAD_LAT-1. While cnt!=0: cnt<=cnt-1. pc_write=if_id_write=!stall_d.
- Each posedge, ID/EX load priority: flush_e > stall_d > normal.
  - flush_e: bubble; cnt<=0 (pending stall cancelled); pc_write/if_id_write still follow stall_d combinationally that cycle.
  - stall_d: bubble.
  - normal: valid_e<=valid_d; control fields <= decoded inputs gated by valid_d (all 0 when valid_d=0); data/index fields <= D values.
- Bubble: valid_e, reg_write_e, mem_read_e, ctrl_e <= 0; data/index/PC fields hold previous value.
- Latency: one cycle D→E. LOAD_LAT=1 gives exactly one bubble per load-use hit.
- Simultaneous WB write and read of same reg: bypass returns result_w; ID/EX captures new value.
- Reset mid-stall: cnt cleared, bubble state, front-end released immediately.

Test Plan:
- Reset, then addi x1 valid with reg_write_d=1 -> next cycle valid_e=1, rd_e=1, reg_write_e=1, pc4_e=pc_d+4.
- lw x5 in E (mem_read_e=1), D add x6,x5,x2 uses_rs1_d=1, LOAD_LAT=1 -> stall_d=1 one cycle, pc_write=0, one bubble (valid_e=0, ctrl_e=0), then add enters E.
- Same with LOAD_LAT=3 -> stall_d=1 for exactly 3 cycles, 3 bubbles, add then enters E once.
- WB writes x7=0xDEADBEEF while D reads rs2=x7 -> rdata2_e=0xDEADBEEF next cycle; WB to x0 -> rdata reads 0, array unchanged.
- flush_e during LOAD_LAT=3 stall (2nd cycle) -> bubble, cnt cleared, stall_d=0 the following cycle.
- lw x0 in E with D reading x0, or valid_d=0 instruction matching rd_e -> no stall.

Source files
------------

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: ID stage with register file, WB bypass, load-use stall and ID/EX register
//   in : clk, rst_n (async, active-low), valid_d/ins_d/pc_d/pc4_d/imm_d/ctrl_d and decoded
//        flags from IF/ID, flush_e from E, reg_write_w/rd_w/result_w from WB
//   out: ID/EX register (valid_e, reg_write_e, mem_read_e, ctrl_e, imm_e, rdata1_e, rdata2_e,
//        pc_e, pc4_e, rs1_e, rs2_e, rd_e), front-end enables pc_write/if_id_write, stall_d
module decode_stage_pipe #(
  parameter int XLEN = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W = 8,
  parameter int LOAD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_d,
  input  logic [31:0]           ins_d,
  input  logic [XLEN-1:0]       pc_d,
  input  logic [XLEN-1:0]       pc4_d,
  input  logic [XLEN-1:0]       imm_d,
  input  logic [CTRL_W-1:0]     ctrl_d,
  input  logic                  reg_write_d,
  input  logic                  mem_read_d,
  input  logic                  uses_rs1_d,
  input  logic                  uses_rs2_d,
  input  logic                  flush_e,
  input  logic                  reg_write_w,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic [XLEN-1:0]       result_w,
  output logic                  valid_e,
  output logic                  reg_write_e,
  output logic                  mem_read_e,
  output logic [CTRL_W-1:0]     ctrl_e,
  output logic [XLEN-1:0]       imm_e,
  output logic [XLEN-1:0]       rdata1_e,
  output logic [XLEN-1:0]       rdata2_e,
  output logic [XLEN-1:0]       pc_e,
  output logic [XLEN-1:0]       pc4_e,
  output logic [REG_ADDR_W-1:0] rs1_e,
  output logic [REG_ADDR_W-1:0] rs2_e,
  output logic [REG_ADDR_W-1:0] rd_e,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  stall_d
);
  localparam int NREG = 2 ** REG_ADDR_W;
  localparam int CW = $clog2(LOAD_LAT + 1);
  logic [XLEN-1:0] regs [NREG];
  logic [REG_ADDR_W-1:0] rs1, rs2, rd;
  logic [XLEN-1:0] rdata1, rdata2;
  logic wb_en, hit;
  logic [CW-1:0] cnt;
  logic unused_ins;
  // only the register index fields are consumed here; opcode decode happens upstream
  assign unused_ins = ^ins_d;
  assign rs1 = ins_d[15 +: REG_ADDR_W];
  assign rs2 = ins_d[20 +: REG_ADDR_W];
  assign rd  = ins_d[7 +: REG_ADDR_W];
  assign wb_en = reg_write_w && rd_w != '0;
  // x0 is never written, so the array read of x0 is always zero
  assign rdata1 = (wb_en && rd_w == rs1) ? result_w : regs[rs1];
  assign rdata2 = (wb_en && rd_w == rs2) ? result_w : regs[rs2];
  assign hit = valid_d && valid_e && mem_read_e && rd_e != '0 &&
               ((uses_rs1_d && rs1 == rd_e) || (uses_rs2_d && rs2 == rd_e));
  // first stall cycle comes from the hit itself; cnt covers the remaining LOAD_LAT-1 cycles
  assign stall_d = (hit && cnt == '0) || cnt != '0;
  assign pc_write = !stall_d;
  assign if_id_write = !stall_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    else if (wb_en)
      regs[rd_w] <= result_w;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      cnt <= '0;
    else if (flush_e)
      cnt <= '0;
    else if (cnt != '0)
      cnt <= cnt - CW'(1);
    else if (hit)
      cnt <= CW'(LOAD_LAT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_e     <= 1'b0;
      reg_write_e <= 1'b0;
      mem_read_e  <= 1'b0;
      ctrl_e      <= '0;
      imm_e       <= '0;
      rdata1_e    <= '0;
      rdata2_e    <= '0;
      pc_e        <= '0;
      pc4_e       <= '0;
      rs1_e       <= '0;
      rs2_e       <= '0;
      rd_e        <= '0;
    end else if (flush_e || stall_d) begin
      // bubble: kill control, leave data fields untouched
      valid_e     <= 1'b0;
      reg_write_e <= 1'b0;
      mem_read_e  <= 1'b0;
      ctrl_e      <= '0;
    end else begin
      valid_e     <= valid_d;
      reg_write_e <= valid_d && reg_write_d;
      mem_read_e  <= valid_d && mem_read_d;
      ctrl_e      <= valid_d ? ctrl_d : '0;
      imm_e       <= imm_d;
      rdata1_e    <= rdata1;
      rdata2_e    <= rdata2;
      pc_e        <= pc_d;
      pc4_e       <= pc4_d;
      rs1_e       <= rs1;
      rs2_e       <= rs2;
      rd_e        <= rd;
    end
endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: directed vector bench for decode_stage_pipe at LOAD_LAT=1 and LOAD_LAT=3
module tb_decode_stage_pipe;
  typedef struct {
    logic v; logic [4:0] rd, rs1, rs2; logic [31:0] pc; logic [7:0] ctrl;
    logic rw, mr, u1, u2, fl, ww; logic [4:0] wd; logic [31:0] wr;
    logic es, ev, erw, emr; logic [7:0] ectrl; logic [4:0] erd; logic [31:0] er1, er2, epc4;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic valid_d, reg_write_d, mem_read_d, uses_rs1_d, uses_rs2_d, flush_e, reg_write_w;
  logic [31:0] ins_d, pc_d, pc4_d, imm_d, result_w;
  logic [7:0] ctrl_d;
  logic [4:0] rd_w;
  logic o1_ve, o1_rwe, o1_mre, o1_pw, o1_ifw, o1_st;
  logic o3_ve, o3_rwe, o3_mre, o3_pw, o3_ifw, o3_st;
  logic [7:0] o1_ctrl, o3_ctrl;
  logic [31:0] o1_imm, o1_r1, o1_r2, o1_pc, o1_pc4, o3_imm, o3_r1, o3_r2, o3_pc, o3_pc4;
  logic [4:0] o1_rs1, o1_rs2, o1_rd, o3_rs1, o3_rs2, o3_rd;
  int nvec = 0, nerr = 0;
  vec_t tv [16];
  vec_t lw5, add6, idle;
  always #5 clk = ~clk;
  decode_stage_pipe #(.LOAD_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .ins_d(ins_d), .pc_d(pc_d), .pc4_d(pc4_d),
    .imm_d(imm_d), .ctrl_d(ctrl_d), .reg_write_d(reg_write_d), .mem_read_d(mem_read_d),
    .uses_rs1_d(uses_rs1_d), .uses_rs2_d(uses_rs2_d), .flush_e(flush_e),
    .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
    .valid_e(o1_ve), .reg_write_e(o1_rwe), .mem_read_e(o1_mre), .ctrl_e(o1_ctrl),
    .imm_e(o1_imm), .rdata1_e(o1_r1), .rdata2_e(o1_r2), .pc_e(o1_pc), .pc4_e(o1_pc4),
    .rs1_e(o1_rs1), .rs2_e(o1_rs2), .rd_e(o1_rd), .pc_write(o1_pw), .if_id_write(o1_ifw),
    .stall_d(o1_st));
  decode_stage_pipe #(.LOAD_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .ins_d(ins_d), .pc_d(pc_d), .pc4_d(pc4_d),
    .imm_d(imm_d), .ctrl_d(ctrl_d), .reg_write_d(reg_write_d), .mem_read_d(mem_read_d),
    .uses_rs1_d(uses_rs1_d), .uses_rs2_d(uses_rs2_d), .flush_e(flush_e),
    .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
    .valid_e(o3_ve), .reg_write_e(o3_rwe), .mem_read_e(o3_mre), .ctrl_e(o3_ctrl),
    .imm_e(o3_imm), .rdata1_e(o3_r1), .rdata2_e(o3_r2), .pc_e(o3_pc), .pc4_e(o3_pc4),
    .rs1_e(o3_rs1), .rs2_e(o3_rs2), .rd_e(o3_rd), .pc_write(o3_pw), .if_id_write(o3_ifw),
    .stall_d(o3_st));
  function automatic vec_t mk(int v, int rd, int rs1, int rs2, int pc, int ctrl, int rw, int mr,
                              int u1, int u2, int fl, int ww, int wd, int wr, int es, int ev,
                              int erw, int emr, int ectrl, int erd, int er1, int er2, int epc4);
    vec_t t;
    t.v = v[0]; t.rd = rd[4:0]; t.rs1 = rs1[4:0]; t.rs2 = rs2[4:0]; t.pc = pc; t.ctrl = ctrl[7:0];
    t.rw = rw[0]; t.mr = mr[0]; t.u1 = u1[0]; t.u2 = u2[0]; t.fl = fl[0]; t.ww = ww[0];
    t.wd = wd[4:0]; t.wr = wr; t.es = es[0]; t.ev = ev[0]; t.erw = erw[0]; t.emr = emr[0];
    t.ectrl = ectrl[7:0]; t.erd = erd[4:0]; t.er1 = er1; t.er2 = er2; t.epc4 = epc4;
    return t;
  endfunction
  task automatic drive(input vec_t t);
    valid_d = t.v;
    ins_d = {7'b0, t.rs2, t.rs1, 3'b0, t.rd, 7'h33};
    pc_d = t.pc;
    pc4_d = t.pc + 32'd4;
    imm_d = t.pc + 32'd1000;
    ctrl_d = t.ctrl;
    reg_write_d = t.rw; mem_read_d = t.mr; uses_rs1_d = t.u1; uses_rs2_d = t.u2;
    flush_e = t.fl; reg_write_w = t.ww; rd_w = t.wd; result_w = t.wr;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic reset_all();
    drive(idle);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask
  initial begin
    idle = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0);
    lw5  = mk(1,5,0,0,'h200,'h44,1,1,1,0,0,0,0,0, 0,0,0,0,0,0,0,0,0);
    add6 = mk(1,6,5,2,'h204,'h55,1,0,1,1,0,0,0,0, 0,0,0,0,0,0,0,0,0);
    tv[0]  = mk(1,1,0,0,'h100,'h11,1,0,1,0,0, 0,0,0,             0,1,1,0,'h11,1,0,0,'h104);
    tv[1]  = mk(1,8,0,7,'h104,'h22,1,0,0,1,0, 1,7,'hDEADBEEF,    0,1,1,0,'h22,8,0,'hDEADBEEF,'h108);
    tv[2]  = mk(1,9,0,7,'h108,'h33,1,0,1,1,0, 1,0,'h12345678,    0,1,1,0,'h33,9,0,'hDEADBEEF,'h10c);
    tv[3]  = mk(1,5,0,0,'h10c,'h44,1,1,1,0,0, 0,0,0,             0,1,1,1,'h44,5,0,0,'h110);
    tv[4]  = mk(1,6,5,2,'h110,'h55,1,0,1,1,0, 0,0,0,             1,0,0,0,0,5,0,0,'h110);
    tv[5]  = mk(1,6,5,2,'h110,'h55,1,0,1,1,0, 1,5,'hCAFE0005,    0,1,1,0,'h55,6,'hCAFE0005,0,'h114);
    tv[6]  = mk(0,3,1,1,'h114,'h66,1,1,1,1,0, 0,0,0,             0,0,0,0,0,3,0,0,'h118);
    tv[7]  = mk(1,0,7,0,'h118,'h77,1,1,1,0,0, 0,0,0,             0,1,1,1,'h77,0,'hDEADBEEF,0,'h11c);
    tv[8]  = mk(1,4,0,0,'h11c,'h08,1,0,1,1,0, 0,0,0,             0,1,1,0,'h08,4,0,0,'h120);
    tv[9]  = mk(1,5,0,0,'h120,'h44,1,1,1,0,0, 0,0,0,             0,1,1,1,'h44,5,0,0,'h124);
    tv[10] = mk(0,6,5,5,'h124,'h99,1,0,1,1,0, 0,0,0,             0,0,0,0,0,6,'hCAFE0005,'hCAFE0005,'h128);
    tv[11] = mk(1,5,0,0,'h128,'h44,1,1,1,0,0, 0,0,0,             0,1,1,1,'h44,5,0,0,'h12c);
    tv[12] = mk(1,1,5,2,'h12c,'h12,0,0,0,1,0, 0,0,0,             0,1,0,0,'h12,1,'hCAFE0005,0,'h130);
    tv[13] = mk(1,5,0,0,'h130,'h44,1,1,1,0,0, 0,0,0,             0,1,1,1,'h44,5,0,0,'h134);
    tv[14] = mk(1,6,2,5,'h134,'h55,1,0,1,1,0, 0,0,0,             1,0,0,0,0,5,0,0,'h134);
    tv[15] = mk(1,6,2,5,'h134,'h55,1,0,1,1,1, 0,0,0,             0,0,0,0,0,5,0,0,'h134);
    drive(idle);
    #3;
    chk("rst_valid_e", 32'(o1_ve), 0);
    chk("rst_rd_e", 32'(o1_rd), 0);
    chk("rst_pc4_e", o1_pc4, 0);
    chk("rst_pc_write", 32'(o1_pw), 1);
    chk("rst_if_id_write", 32'(o1_ifw), 1);
    chk("rst_stall", 32'(o1_st), 0);
    chk("rst_stall3", 32'(o3_st), 0);
    #9;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d_stall_d", i), 32'(o1_st), 32'(tv[i].es));
      chk($sformatf("v%0d_pc_write", i), 32'(o1_pw), 32'(!tv[i].es));
      chk($sformatf("v%0d_if_id_write", i), 32'(o1_ifw), 32'(!tv[i].es));
      tick();
      chk($sformatf("v%0d_valid_e", i), 32'(o1_ve), 32'(tv[i].ev));
      chk($sformatf("v%0d_reg_write_e", i), 32'(o1_rwe), 32'(tv[i].erw));
      chk($sformatf("v%0d_mem_read_e", i), 32'(o1_mre), 32'(tv[i].emr));
      chk($sformatf("v%0d_ctrl_e", i), 32'(o1_ctrl), 32'(tv[i].ectrl));
      chk($sformatf("v%0d_rd_e", i), 32'(o1_rd), 32'(tv[i].erd));
      chk($sformatf("v%0d_rdata1_e", i), o1_r1, tv[i].er1);
      chk($sformatf("v%0d_rdata2_e", i), o1_r2, tv[i].er2);
      chk($sformatf("v%0d_pc4_e", i), o1_pc4, tv[i].epc4);
      chk($sformatf("v%0d_pc_e", i), o1_pc, tv[i].epc4 - 32'd4);
      chk($sformatf("v%0d_imm_e", i), o1_imm, tv[i].epc4 + 32'd996);
    end
    reset_all();
    drive(lw5);
    tick();
    chk("a_lw_mem_read_e", 32'(o3_mre), 1);
    drive(add6);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("a%0d_stall_d", i), 32'(o3_st), 32'(i < 3));
      chk($sformatf("a%0d_pc_write", i), 32'(o3_pw), 32'(i == 3));
      tick();
      chk($sformatf("a%0d_valid_e", i), 32'(o3_ve), 32'(i == 3));
      chk($sformatf("a%0d_ctrl_e", i), 32'(o3_ctrl), i == 3 ? 32'h55 : 32'h0);
    end
    chk("a_rd_e", 32'(o3_rd), 6);
    chk("a_rs1_e", 32'(o3_rs1), 5);
    chk("a_rs2_e", 32'(o3_rs2), 2);
    chk("a_pc_e", o3_pc, 32'h204);
    drive(idle);
    #1;
    chk("a_idle_stall_d", 32'(o3_st), 0);
    tick();
    chk("a_idle_valid_e", 32'(o3_ve), 0);
    reset_all();
    drive(lw5);
    tick();
    drive(add6);
    #1;
    chk("b_stall1", 32'(o3_st), 1);
    tick();
    flush_e = 1'b1;
    #1;
    chk("b_stall2_flush", 32'(o3_st), 1);
    chk("b_pc_write_flush", 32'(o3_pw), 0);
    tick();
    chk("b_flush_valid_e", 32'(o3_ve), 0);
    flush_e = 1'b0;
    #1;
    chk("b_after_flush_stall", 32'(o3_st), 0);
    chk("b_after_flush_pc_write", 32'(o3_pw), 1);
    tick();
    chk("b_add_valid_e", 32'(o3_ve), 1);
    chk("b_add_rd_e", 32'(o3_rd), 6);
    reset_all();
    drive(lw5);
    tick();
    drive(add6);
    #1;
    chk("c_stall1", 32'(o3_st), 1);
    tick();
    chk("c_stall2", 32'(o3_st), 1);
    rst_n = 1'b0;
    #1;
    chk("c_rst_stall", 32'(o3_st), 0);
    chk("c_rst_pc_write", 32'(o3_pw), 1);
    chk("c_rst_valid_e", 32'(o3_ve), 0);
    chk("c_rst_mem_read_e", 32'(o3_mre), 0);
    rst_n = 1'b1;
    tick();
    chk("c_add_valid_e", 32'(o3_ve), 1);
    chk("c_add_rd_e", 32'(o3_rd), 6);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
